icache_axi_rd_bridge: RTL

- Memory-side stage directly downstream of the instruction cache miss port.
- Converts a single-word miss request (m_strobe/m_a) into one AXI4 read transaction (AR + R channels).
- Returns the word on m_dout with a one-cycle m_ready pulse.
- At most one transaction outstanding. Requests abandoned by the cache are drained silently.

---
 rtl/axi_pkg.sv | 20 ++
 rtl/icache_axi_rd_bridge.sv | 112 +++++++++++
 2 files changed

// File: rtl/axi_pkg.sv
// AXI4 encodings and bridge state type shared by the icache miss path.
// Imported by icache_axi_rd_bridge.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } bridge_state_t;

endpackage

// File: rtl/icache_axi_rd_bridge.sv
// Turns one icache miss (m_strobe/m_a) into a single-beat AXI4 read.
// Abandoned requests still finish on the bus but are dropped silently.
module icache_axi_rd_bridge
  import axi_pkg::*;
#(
  parameter int A_WIDTH  = 32,
  parameter int ID_WIDTH = 4,
  parameter int AXI_ID   = 0
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic [A_WIDTH-1:0]  m_a,
  input  logic                m_strobe,
  output logic [31:0]         m_dout,
  output logic                m_ready,
  output logic                bus_err,
  output logic [ID_WIDTH-1:0] arid,
  output logic [A_WIDTH-1:0]  araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  bridge_state_t state;
  logic          discard;
  logic          abandon;
  logic          unused_ok;

  assign arid    = ID_WIDTH'(AXI_ID);
  assign arlen   = 8'd0;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

  assign abandon = !m_strobe
                || (m_a[A_WIDTH-1:2] != araddr[A_WIDTH-1:2]);

  assign unused_ok = ^{m_a[1:0], rresp[0], rlast, rid};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      m_ready <= 1'b0;
      bus_err <= 1'b0;
      m_dout  <= '0;
      araddr  <= '0;
      discard <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (m_strobe) begin
            araddr  <= {m_a[A_WIDTH-1:2], 2'b00};
            discard <= 1'b0;
            arvalid <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (abandon) discard <= 1'b1;
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (abandon) discard <= 1'b1;
          if (rvalid) begin
            rready <= 1'b0;
            // late abandonment still suppresses this response
            if (discard || abandon) begin
              state <= IDLE;
            end else begin
              m_dout  <= rdata;
              m_ready <= 1'b1;
              bus_err <= rresp[1];
              state   <= RESP;
            end
          end
        end
        RESP: begin
          m_ready <= 1'b0;
          bus_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_rlast: assert property (
    @(posedge clk) disable iff (!clrn)
    (rvalid && rready) |-> rlast);

  a_r_in_data: assert property (
    @(posedge clk) disable iff (!clrn)
    (rvalid && rready) |-> (state == DATA));

  a_ar_stable: assert property (
    @(posedge clk) disable iff (!clrn)
    (arvalid && !arready) |=> (arvalid && $stable(araddr)));

endmodule
